mbc5_mapper_gen2: RTL and testbench
===================================

# mbc5_mapper_gen2

Parametrised, fully clock-synchronous Game Boy cartridge mapper; successor to the 2MB/32KB MBC5-1 hybrid CPLD. Sits between the cartridge edge (A15–A12, D7–D0, /CS, /WR, /RD) and the flash ROM upper address lines, FRAM upper address lines and FRAM /CE. Auto-detects MBC1 or MBC5 software behaviour and locks into that mode until reset. Generates an FRAM /CE precharge gap on every new RAM access.

## Interface
- ROM_BANK_W, 9, ROM bank register width; drives ROM A14 and up (9 = 8MB).
- RAM_BANK_W, 2, RAM bank register width; drives FRAM A13 and up (2 = 32KB). Range 1–4.
- PRECHARGE_CYCLES, 2, clocks /CE is held high at the start of each RAM access. Range 1–15.

- clock  in  1  free-running mapper clock, ≥8 MHz, asynchronous to the cartridge bus
- reset  in  1  asynchronous, active-low
- inputAddress  in  4  A15–A12
- inputData  in  8  D7–D0
- inputCE  in  1  cartridge /CS, active-low
- inputWR  in  1  /WR, active-low
- inputRD  in  1  /RD, active-low
- romBank  out  ROM_BANK_W  ROM A14 and up
- ramBank  out  RAM_BANK_W  FRAM A13 and up
- ramCE  out  1  FRAM /CE, active-low
- mode  out  2  0 = DETECT, 1 = MBC1, 2 = MBC5

## Operation
- inputCE/WR/RD pass through two-flop synchronisers. inputAddress/inputData are captured every clock while synchronised WR is low.
- A write commits on the synchronised WR rising edge, using the last captured address/data.
- Registers: bankLo[7:0] (reset 1), bankHi (reset 0), ramSel[RAM_BANK_W-1:0] (reset 0), ramEnabled (reset 0), mbc1Mode (reset 0), flags zeroSeen/mode6Seen (reset 0).
- Write decode:
  - 0x0000–1FFF: ramEnabled = (data[3:0] == 0xA).
  - 0x2000–2FFF: bankLo = data; data == 0 sets zeroSeen.
  - 0x3000–3FFF: bankHi = data[0].
  - 0x4000–5FFF: ramSel = data[RAM_BANK_W-1:0].
  - 0x6000–7FFF: mbc1Mode = data[0]; sets mode6Seen.
- Mode FSM:
  - DETECT → MBC5 on any of: bankLo write ≥ 32; any 0x3000–3FFF write; ramSel write with data ≥ 4.
  - DETECT → MBC1 when zeroSeen and mode6Seen are both set and MBC5 has not already triggered.
  - MBC1 and MBC5 are terminal until reset.
  - DETECT behaves as MBC5, except that bank 0 in bankLo is translated to 1.
- Effective ROM bank:
  - MBC5: {bankHi, bankLo}.
  - MBC1: {ramSel[1:0], bankLo[4:0]}, with bankLo[4:0] == 0 translated to 1. In mbc1Mode 1, accesses to 0x0000–3FFF use {ramSel[1:0], 5'b0}.
  - Result is truncated to ROM_BANK_W.
- Output romBank:
  - Accesses to 0x0000–3FFF drive 0, except in MBC1 mode 1 as above.
  - Accesses to 0x4000–7FFF drive the effective bank.
  - Holds its last value when the bus is idle.
- Output ramBank: ramSel; forced to 0 in MBC1 mode 0.
- RAM access: address 0xA000–0xBFFF, ramEnabled set, synchronised CE low, and RD or WR low.
  - ramCE stays high outside RAM accesses.
  - ramCE goes low after the precharge (see Configuration).

## Timing
- Reset values: romBank = 0, ramBank = 0, ramCE = 1, mode = 0.
- Write-to-register latency: 3 clocks after the raw WR rising edge (2 sync + 1 commit). Outputs follow 1 clock later.
- Access-to-romBank latency: 3 clocks after address/RD are valid.
- Simultaneous events in one commit cycle:
  - DETECT→MBC5 has priority over DETECT→MBC1.
  - When a write also triggers a mode change, that write's register update applies in the new mode.
- A new RAM access is a transition from non-RAM-access to RAM-access. Back-to-back RAM accesses with no idle clock between them do not re-trigger precharge.
- Reset mid-access: ramCE goes high immediately (asynchronously), the FSM returns to DETECT, and the precharge counter clears.
- bankLo wraps by truncation: 8-bit writes, no saturation.

## Configuration
- FRAM_PRECHARGE_EN defined:
  - On each new RAM access, ramCE stays high for PRECHARGE_CYCLES clocks (4-bit counter), then goes low until the access ends.
  - If the access ends before the count completes, the counter clears and ramCE never asserts.
- FRAM_PRECHARGE_EN undefined:
  - No counter.
  - ramCE goes low 1 clock after RAM-access detection and high 1 clock after it ends.

## Test plan
- Reset, then read 0x4000 → romBank = 1, ramBank = 0, ramCE = 1, mode = 0 after 3 clocks.
- Write 0x40 to 0x2000, write 0x01 to 0x3000, read 0x4000 → mode = 2, romBank = 0x140 (ROM_BANK_W = 9).
- Write 0x00 to 0x2000, write 0x01 to 0x6000, write 0x02 to 0x4000 → mode = 1; read 0x4000 gives romBank = 0x41; read 0x0000 gives romBank = 0x40.
- Write 0x0A to 0x0000, write 0x03 to 0x4000 (mode 2), read 0xA000 held for 10 clocks → ramBank = 3. With FRAM_PRECHARGE_EN and PRECHARGE_CYCLES = 2: ramCE high for 2 clocks after detection, then low until RD rises. Without the macro: ramCE low 1 clock after detection.
- RAM disabled (write 0x00 to 0x0000), then access 0xA000 → ramCE stays 1.
- Assert reset during an active RAM access with mode = 2 → ramCE = 1 and mode = 0 asynchronously; bankLo = 1 once reset releases.

Source files
------------

// File: rtl/mbc5_mapper_gen2_if.sv
// Cartridge-edge bus bundle for mbc5_mapper_gen2: raw bus inputs plus the
// ROM/FRAM upper-address, FRAM /CE and detected-mode outputs.
interface mbc5_mapper_gen2_if #(
  parameter int ROM_BANK_W = 9,
  parameter int RAM_BANK_W = 2
);
  logic [3:0]            inputAddress;
  logic [7:0]            inputData;
  logic                  inputCE;
  logic                  inputWR;
  logic                  inputRD;
  logic [ROM_BANK_W-1:0] romBank;
  logic [RAM_BANK_W-1:0] ramBank;
  logic                  ramCE;
  logic [1:0]            mode;

  modport master (
    output inputAddress, inputData, inputCE, inputWR, inputRD,
    input  romBank, ramBank, ramCE, mode
  );

  modport slave (
    input  inputAddress, inputData, inputCE, inputWR, inputRD,
    output romBank, ramBank, ramCE, mode
  );
endinterface

// File: rtl/mbc5_mapper_gen2.sv
// mbc5_mapper_gen2: clock-synchronous Game Boy cartridge mapper with MBC1/MBC5
// auto-detection. Optional macro FRAM_PRECHARGE_EN adds a PRECHARGE_CYCLES-long
// /CE high gap at the start of every new FRAM access.
module mbc5_mapper_gen2 #(
  parameter int ROM_BANK_W       = 9,
  parameter int RAM_BANK_W       = 2,
  parameter int PRECHARGE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  mbc5_mapper_gen2_if.slave bus
);
  typedef enum logic [1:0] {DETECT = 2'd0, MBC1 = 2'd1, MBC5 = 2'd2} mode_e;

  localparam int EW = (ROM_BANK_W > 9) ? ROM_BANK_W : 9;

  if (RAM_BANK_W < 1 || RAM_BANK_W > 4 || PRECHARGE_CYCLES < 1 || PRECHARGE_CYCLES > 15) begin : g_bad_param
    $error("mbc5_mapper_gen2: parameter out of range");
  end

  logic ce_s1_q, ce_s2_q, wr_s1_q, wr_s2_q, rd_s1_q, rd_s2_q, wr_prev_q;
  logic [3:0] a_s1_q, a_s2_q, wa_q;
  logic [7:0] wd_q;
  logic commit;

  logic [7:0]            bankLo_q, bankLo_d;
  logic                  bankHi_q, bankHi_d;
  logic [RAM_BANK_W-1:0] ramSel_q, ramSel_d;
  logic                  ramEn_q, ramEn_d, mbc1Mode_q, mbc1Mode_d;
  logic                  zero_q, zero_d, mode6_q, mode6_d, mbc5_hit;
  mode_e                 state_q, state_d;

  logic [ROM_BANK_W-1:0] romBank_q;
  logic [RAM_BANK_W-1:0] ramBank_q;
  logic                  ramCE_q, ram_access, rom_read;
  logic [EW-1:0]         eff;
  logic [1:0]            sel2;
  logic [7:0]            lo_fix;
  logic [4:0]            lo5;

  // Two-flop synchronisers for the bus strobes and address; write capture while WR is low
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      {ce_s1_q, ce_s2_q, wr_s1_q, wr_s2_q, rd_s1_q, rd_s2_q, wr_prev_q} <= '1;
      a_s1_q <= '0;
      a_s2_q <= '0;
      wa_q   <= '0;
      wd_q   <= '0;
    end else begin
      ce_s1_q   <= bus.inputCE;
      ce_s2_q   <= ce_s1_q;
      wr_s1_q   <= bus.inputWR;
      wr_s2_q   <= wr_s1_q;
      rd_s1_q   <= bus.inputRD;
      rd_s2_q   <= rd_s1_q;
      a_s1_q    <= bus.inputAddress;
      a_s2_q    <= a_s1_q;
      wr_prev_q <= wr_s2_q;
      if (!wr_s2_q) begin
        wa_q <= bus.inputAddress;
        wd_q <= bus.inputData;
      end
    end
  end

  assign commit = wr_s2_q & ~wr_prev_q;

  // Register write decode on the synchronised WR rising edge
  always_comb begin
    bankLo_d   = bankLo_q;
    bankHi_d   = bankHi_q;
    ramSel_d   = ramSel_q;
    ramEn_d    = ramEn_q;
    mbc1Mode_d = mbc1Mode_q;
    zero_d     = zero_q;
    mode6_d    = mode6_q;
    mbc5_hit   = 1'b0;
    if (commit) begin
      case (wa_q)
        4'h0, 4'h1: ramEn_d = (wd_q[3:0] == 4'hA);
        4'h2: begin
          bankLo_d = wd_q;
          if (wd_q == 8'd0)  zero_d   = 1'b1;
          if (wd_q >= 8'd32) mbc5_hit = 1'b1;
        end
        4'h3: begin
          bankHi_d = wd_q[0];
          mbc5_hit = 1'b1;
        end
        4'h4, 4'h5: begin
          ramSel_d = wd_q[RAM_BANK_W-1:0];
          if (wd_q >= 8'd4) mbc5_hit = 1'b1;
        end
        4'h6, 4'h7: begin
          mbc1Mode_d = wd_q[0];
          mode6_d    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Mode detection: MBC5 evidence wins over MBC1 evidence in the same commit; both terminal
  always_comb begin
    state_d = state_q;
    if (state_q == DETECT) begin
      if (mbc5_hit)               state_d = MBC5;
      else if (zero_d && mode6_d) state_d = MBC1;
    end
  end

  // Mapper registers and mode state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bankLo_q   <= 8'd1;
      bankHi_q   <= 1'b0;
      ramSel_q   <= '0;
      ramEn_q    <= 1'b0;
      mbc1Mode_q <= 1'b0;
      zero_q     <= 1'b0;
      mode6_q    <= 1'b0;
      state_q    <= DETECT;
    end else begin
      bankLo_q   <= bankLo_d;
      bankHi_q   <= bankHi_d;
      ramSel_q   <= ramSel_d;
      ramEn_q    <= ramEn_d;
      mbc1Mode_q <= mbc1Mode_d;
      zero_q     <= zero_d;
      mode6_q    <= mode6_d;
      state_q    <= state_d;
    end
  end

  assign sel2   = 2'(ramSel_q);
  assign lo_fix = (bankLo_q == 8'd0) ? 8'd1 : bankLo_q;
  assign lo5    = (bankLo_q[4:0] == 5'd0) ? 5'd1 : bankLo_q[4:0];

  // ROM bank seen by the current (synchronised) read address
  always_comb begin
    eff = '0;
    case (state_q)
      MBC1: begin
        if (a_s2_q[2]) eff = EW'({sel2, lo5});
        else if (mbc1Mode_q) eff = EW'({sel2, 5'd0});
      end
      MBC5:    if (a_s2_q[2]) eff = EW'({bankHi_q, bankLo_q});
      default: if (a_s2_q[2]) eff = EW'({bankHi_q, lo_fix});
    endcase
  end

  assign rom_read   = !rd_s2_q && !a_s2_q[3];
  assign ram_access = (a_s2_q[3:1] == 3'b101) && ramEn_q && !ce_s2_q && (!rd_s2_q || !wr_s2_q);

`ifdef FRAM_PRECHARGE_EN
  logic [3:0] pre_cnt_q;
`endif

  // Output registers: ROM bank held while idle, RAM bank, FRAM /CE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      romBank_q <= '0;
      ramBank_q <= '0;
      ramCE_q   <= 1'b1;
`ifdef FRAM_PRECHARGE_EN
      pre_cnt_q <= '0;
`endif
    end else begin
      if (rom_read) romBank_q <= eff[ROM_BANK_W-1:0];
      ramBank_q <= (state_q == MBC1 && !mbc1Mode_q) ? '0 : ramSel_q;
`ifdef FRAM_PRECHARGE_EN
      // Counter only runs from zero on a fresh access, so back-to-back accesses don't re-precharge
      if (!ram_access) begin
        pre_cnt_q <= '0;
        ramCE_q   <= 1'b1;
      end else if (pre_cnt_q < 4'(PRECHARGE_CYCLES)) begin
        pre_cnt_q <= pre_cnt_q + 4'd1;
        ramCE_q   <= 1'b1;
      end else begin
        ramCE_q   <= 1'b0;
      end
`else
      ramCE_q <= !ram_access;
`endif
    end
  end

  assign bus.romBank = romBank_q;
  assign bus.ramBank = ramBank_q;
  assign bus.ramCE   = ramCE_q;
  assign bus.mode    = state_q;
endmodule

// File: tb/tb_mbc5_mapper_gen2.sv
// Directed self-checking bench for mbc5_mapper_gen2 (ROM_BANK_W=9, RAM_BANK_W=2,
// PRECHARGE_CYCLES=2). Honours FRAM_PRECHARGE_EN for the /CE timing checks.
module tb_mbc5_mapper_gen2;
  localparam int PC = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  mbc5_mapper_gen2_if #(.ROM_BANK_W(9), .RAM_BANK_W(2)) bus ();

  mbc5_mapper_gen2 #(.ROM_BANK_W(9), .RAM_BANK_W(2), .PRECHARGE_CYCLES(PC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.inputAddress = a;
    bus.inputData    = d;
    bus.inputWR      = 1'b0;
    tick(3);
    bus.inputWR      = 1'b1;
    tick(5);
  endtask

  task automatic rd_rom(input logic [3:0] a);
    bus.inputAddress = a;
    bus.inputRD      = 1'b0;
    tick(4);
  endtask

  task automatic rd_end();
    bus.inputRD = 1'b1;
    bus.inputCE = 1'b1;
    tick(3);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
  endtask

  initial begin
    bus.inputAddress = 4'h0;
    bus.inputData    = 8'h00;
    bus.inputCE      = 1'b1;
    bus.inputWR      = 1'b1;
    bus.inputRD      = 1'b1;
    tick(2);
    check("rst_romBank", 32'(bus.romBank), 32'h0);
    check("rst_ramBank", 32'(bus.ramBank), 32'h0);
    check("rst_ramCE",   32'(bus.ramCE),   32'h1);
    check("rst_mode",    32'(bus.mode),    32'h0);
    reset = 1'b1;
    tick(2);

    // DETECT default bank
    rd_rom(4'h4);
    check("det_romBank", 32'(bus.romBank), 32'h1);
    check("det_ramBank", 32'(bus.ramBank), 32'h0);
    check("det_ramCE",   32'(bus.ramCE),   32'h1);
    check("det_mode",    32'(bus.mode),    32'h0);
    rd_end();

    // MBC1 detection and banking
    wr(4'h2, 8'h00);
    check("zero_only_mode", 32'(bus.mode), 32'h0);
    wr(4'h6, 8'h01);
    check("mbc1_mode", 32'(bus.mode), 32'h1);
    wr(4'h4, 8'h02);
    check("mbc1_ramBank_m1", 32'(bus.ramBank), 32'h2);
    rd_rom(4'h4);
    check("mbc1_rom_4000", 32'(bus.romBank), 32'h41);
    rd_end();
    rd_rom(4'h0);
    check("mbc1_rom_0000_m1", 32'(bus.romBank), 32'h40);
    rd_end();
    wr(4'h6, 8'h00);
    check("mbc1_ramBank_m0", 32'(bus.ramBank), 32'h0);
    rd_rom(4'h0);
    check("mbc1_rom_0000_m0", 32'(bus.romBank), 32'h0);
    rd_end();
    check("mbc1_rom_hold", 32'(bus.romBank), 32'h0);

    do_reset();
    check("rst2_mode", 32'(bus.mode), 32'h0);

    // MBC5 detection and 9-bit banking
    wr(4'h2, 8'h40);
    check("mbc5_mode", 32'(bus.mode), 32'h2);
    wr(4'h3, 8'h01);
    rd_rom(4'h4);
    check("mbc5_rom_140", 32'(bus.romBank), 32'h140);
    rd_end();
    rd_rom(4'h0);
    check("mbc5_rom_0000", 32'(bus.romBank), 32'h0);
    rd_end();
    wr(4'h2, 8'h00);
    rd_rom(4'h4);
    check("mbc5_rom_bank0", 32'(bus.romBank), 32'h100);
    rd_end();

    // RAM access with /CE timing
    wr(4'h0, 8'h0A);
    wr(4'h4, 8'h03);
    check("mbc5_ramBank", 32'(bus.ramBank), 32'h3);
    check("mbc5_mode_keep", 32'(bus.mode), 32'h2);
    bus.inputAddress = 4'hA;
    bus.inputCE      = 1'b0;
    bus.inputRD      = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
`ifdef FRAM_PRECHARGE_EN
      check($sformatf("ramCE_clk%0d", k), 32'(bus.ramCE), (k >= 3 + PC) ? 32'h0 : 32'h1);
`else
      check($sformatf("ramCE_clk%0d", k), 32'(bus.ramCE), (k >= 3) ? 32'h0 : 32'h1);
`endif
    end
    bus.inputRD = 1'b1;
    tick(2);
    check("ramCE_end_hold", 32'(bus.ramCE), 32'h0);
    tick(1);
    check("ramCE_end_high", 32'(bus.ramCE), 32'h1);
    bus.inputCE = 1'b1;
    tick(3);

`ifdef FRAM_PRECHARGE_EN
    // Access shorter than the precharge never asserts /CE
    bus.inputCE = 1'b0;
    bus.inputRD = 1'b0;
    tick(2);
    bus.inputRD = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("short_ramCE", 32'(bus.ramCE), 32'h1);
    end
    bus.inputCE = 1'b1;
    tick(2);
`endif

    // RAM disabled
    wr(4'h0, 8'h00);
    bus.inputAddress = 4'hA;
    bus.inputCE      = 1'b0;
    bus.inputRD      = 1'b0;
    tick(3);
    check("dis_ramCE_mid", 32'(bus.ramCE), 32'h1);
    tick(5);
    check("dis_ramCE_end", 32'(bus.ramCE), 32'h1);
    rd_end();

    // Asynchronous reset during an active RAM access
    wr(4'h0, 8'h0A);
    bus.inputAddress = 4'hA;
    bus.inputCE      = 1'b0;
    bus.inputRD      = 1'b0;
    tick(8);
    check("pre_rst_ramCE", 32'(bus.ramCE), 32'h0);
    check("pre_rst_mode",  32'(bus.mode),  32'h2);
    #2 reset = 1'b0;
    #1;
    check("async_rst_ramCE", 32'(bus.ramCE), 32'h1);
    check("async_rst_mode",  32'(bus.mode),  32'h0);
    bus.inputCE = 1'b1;
    bus.inputRD = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);
    rd_rom(4'h4);
    check("post_rst_romBank", 32'(bus.romBank), 32'h1);
    check("post_rst_ramCE",   32'(bus.ramCE),   32'h1);
    rd_end();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
